// File: rtl/shop_ctrl_v_if.sv
// rtl/shop_ctrl_v_if.sv - token/response bus between token source and shop_ctrl_v
// Ports (signals):
//   i_rdy       token strobe, one token per 0->1 transition
//   i_a         ASCII token, right-justified
//   o_a         ASCII response, right-justified
//   o_vld       one-cycle pulse when o_a is updated
//   o_cur_user  logged-in user slot
//   o_logged_in session active
interface shop_ctrl_v_if #(
    parameter int I_A_NUM_BITS = 56,
    parameter int O_A_NUM_BITS = 72,
    parameter int CUR_W        = 3
);
    logic                    i_rdy;
    logic [I_A_NUM_BITS-1:0] i_a;
    logic [O_A_NUM_BITS-1:0] o_a;
    logic                    o_vld;
    logic [CUR_W-1:0]        o_cur_user;
    logic                    o_logged_in;

    modport master (output i_rdy, i_a, input o_a, o_vld, o_cur_user, o_logged_in);
    modport slave  (input i_rdy, i_a, output o_a, o_vld, o_cur_user, o_logged_in);
endinterface

// File: rtl/shop_ctrl_v.sv
// rtl/shop_ctrl_v.sv - shop database controller: login dialogue, user table with lockout, item stock table
// Ports:
//   i_clk      clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   bus        shop_ctrl_v_if.slave: i_rdy/i_a token in, o_a/o_vld response out, o_cur_user/o_logged_in session
module shop_ctrl_v #(
    parameter int I_A_NUM_ASCII_CHARS = 7,
    parameter int O_A_NUM_ASCII_CHARS = 9,
    parameter int MAX_USERS           = 5,
    parameter int MAX_ITEMS           = 8,
    parameter int QTY_W               = 8,
    parameter int MAX_LOGIN_FAILS     = 3,
    parameter     ADMIN_USERNAME      = "Adm",
    parameter     ADMIN_PASSWORD      = "123"
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    shop_ctrl_v_if.slave bus
);
    localparam int I_W = 8 * I_A_NUM_ASCII_CHARS;
    localparam int O_W = 8 * O_A_NUM_ASCII_CHARS;
    localparam int UW  = $clog2(MAX_USERS);
    localparam int IW  = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1;

    typedef enum logic [3:0] {
        S_CMD, S_USER, S_PASS, S_NUSER, S_NPASS, S_DUSER, S_ITEM, S_QTY, S_DITEM, S_BUY
    } state_t;

    state_t             state_q, state_d;
    logic               rdy_q;
    logic               tok;
    logic [O_W-1:0]     o_a_q, o_a_d;
    logic               vld_q, vld_d;
    logic               logged_q, logged_d;
    logic [UW-1:0]      cur_q, cur_d;
    logic [UW-1:0]      uslot_q, uslot_d;   // user slot latched between dialogue steps
    logic [IW-1:0]      islot_q, islot_d;   // item slot latched between ITEM and QTY
    logic               inew_q, inew_d;     // latched item slot is a fresh allocation
    logic [I_W-1:0]     name_q, name_d;     // pending name for a new user/item

    logic [MAX_USERS-1:0] user_vld_q, user_vld_d, locked_q, locked_d;
    logic [I_W-1:0]       user_name_q [MAX_USERS];
    logic [I_W-1:0]       user_name_d [MAX_USERS];
    logic [I_W-1:0]       user_pass_q [MAX_USERS];
    logic [I_W-1:0]       user_pass_d [MAX_USERS];
    logic [3:0]           fails_q [MAX_USERS];
    logic [3:0]           fails_d [MAX_USERS];

    logic [MAX_ITEMS-1:0] item_vld_q, item_vld_d;
    logic [I_W-1:0]       item_name_q [MAX_ITEMS];
    logic [I_W-1:0]       item_name_d [MAX_ITEMS];
    logic [QTY_W-1:0]     item_qty_q [MAX_ITEMS];
    logic [QTY_W-1:0]     item_qty_d [MAX_ITEMS];

    logic               u_hit, u_free, i_hit, i_free;
    logic [UW-1:0]      u_idx, u_free_idx;
    logic [IW-1:0]      i_idx, i_free_idx;
    logic [4:0]         nfail;
    logic [QTY_W:0]     qsum;
    logic               is_admin;

    assign tok      = bus.i_rdy & ~rdy_q;
    assign is_admin = logged_q && (cur_q == '0);

    assign bus.o_a         = o_a_q;
    assign bus.o_vld       = vld_q;
    assign bus.o_cur_user  = cur_q;
    assign bus.o_logged_in = logged_q;

    // Parallel lookups; descending scan so the lowest index wins.
    always_comb begin
        u_hit = 1'b0; u_idx = '0; u_free = 1'b0; u_free_idx = '0;
        i_hit = 1'b0; i_idx = '0; i_free = 1'b0; i_free_idx = '0;
        for (int i = MAX_USERS - 1; i >= 0; i--) begin
            if (user_vld_q[i] && user_name_q[i] == bus.i_a) begin u_hit = 1'b1; u_idx = UW'(i); end
            if (!user_vld_q[i]) begin u_free = 1'b1; u_free_idx = UW'(i); end
        end
        for (int i = MAX_ITEMS - 1; i >= 0; i--) begin
            if (item_vld_q[i] && item_name_q[i] == bus.i_a) begin i_hit = 1'b1; i_idx = IW'(i); end
            if (!item_vld_q[i]) begin i_free = 1'b1; i_free_idx = IW'(i); end
        end
    end

    always_comb begin
        state_d     = state_q;
        o_a_d       = o_a_q;
        vld_d       = 1'b0;
        logged_d    = logged_q;
        cur_d       = cur_q;
        uslot_d     = uslot_q;
        islot_d     = islot_q;
        inew_d      = inew_q;
        name_d      = name_q;
        user_vld_d  = user_vld_q;
        locked_d    = locked_q;
        user_name_d = user_name_q;
        user_pass_d = user_pass_q;
        fails_d     = fails_q;
        item_vld_d  = item_vld_q;
        item_name_d = item_name_q;
        item_qty_d  = item_qty_q;
        nfail       = {1'b0, fails_q[uslot_q]} + 5'd1;
        qsum        = {1'b0, item_qty_q[islot_q]} + {1'b0, bus.i_a[QTY_W-1:0]};
        if (tok) begin
            vld_d   = 1'b1;
            state_d = S_CMD;
            unique case (state_q)
                S_CMD: begin
                    if (bus.i_a == I_W'("Login")) begin
                        if (!logged_q) begin o_a_d = O_W'("Username?"); state_d = S_USER; end
                        else o_a_d = O_W'("InvalPerm");
                    end else if (bus.i_a == I_W'("Logout")) begin
                        if (logged_q) begin o_a_d = O_W'("Cmd?"); logged_d = 1'b0; cur_d = '0; end
                        else o_a_d = O_W'("InvalPerm");
                    end else if (bus.i_a == I_W'("AddUsr")) begin
                        if (is_admin) begin o_a_d = O_W'("Username?"); state_d = S_NUSER; end
                        else o_a_d = O_W'("InvalPerm");
                    end else if (bus.i_a == I_W'("DelUsr")) begin
                        if (is_admin) begin o_a_d = O_W'("Username?"); state_d = S_DUSER; end
                        else o_a_d = O_W'("InvalPerm");
                    end else if (bus.i_a == I_W'("AddItem")) begin
                        if (is_admin) begin o_a_d = O_W'("Item?"); state_d = S_ITEM; end
                        else o_a_d = O_W'("InvalPerm");
                    end else if (bus.i_a == I_W'("DelItem")) begin
                        if (is_admin) begin o_a_d = O_W'("Item?"); state_d = S_DITEM; end
                        else o_a_d = O_W'("InvalPerm");
                    end else if (bus.i_a == I_W'("Buy")) begin
                        if (logged_q) begin o_a_d = O_W'("Item?"); state_d = S_BUY; end
                        else o_a_d = O_W'("InvalPerm");
                    end else begin
                        o_a_d = O_W'("InvalCmd");
                    end
                end
                S_USER: begin
                    if (!u_hit) o_a_d = O_W'("InvalUser");
                    else if (locked_q[u_idx]) o_a_d = O_W'("Locked");
                    else begin o_a_d = O_W'("Password?"); uslot_d = u_idx; state_d = S_PASS; end
                end
                S_PASS: begin
                    if (user_pass_q[uslot_q] == bus.i_a) begin
                        o_a_d = O_W'("OK"); logged_d = 1'b1; cur_d = uslot_q; fails_d[uslot_q] = 4'd0;
                    end else begin
                        o_a_d = O_W'("InvalPass");
                        if (fails_q[uslot_q] != 4'hF) fails_d[uslot_q] = nfail[3:0];
                        // Admin keeps counting but can never be locked out.
                        if (uslot_q != '0 && nfail >= 5'(MAX_LOGIN_FAILS)) locked_d[uslot_q] = 1'b1;
                    end
                end
                S_NUSER: begin
                    if (u_hit) o_a_d = O_W'("InvalUser");
                    else if (!u_free) o_a_d = O_W'("Full");
                    else begin
                        o_a_d = O_W'("Password?"); name_d = bus.i_a; uslot_d = u_free_idx; state_d = S_NPASS;
                    end
                end
                S_NPASS: begin
                    user_vld_d[uslot_q]  = 1'b1;
                    user_name_d[uslot_q] = name_q;
                    user_pass_d[uslot_q] = bus.i_a;
                    fails_d[uslot_q]     = 4'd0;
                    locked_d[uslot_q]    = 1'b0;
                    o_a_d                = O_W'("OK");
                end
                S_DUSER: begin
                    if (u_hit && u_idx == '0) o_a_d = O_W'("InvalPerm");
                    else if (!u_hit) o_a_d = O_W'("InvalUser");
                    else begin
                        user_vld_d[u_idx] = 1'b0; locked_d[u_idx] = 1'b0; fails_d[u_idx] = 4'd0;
                        o_a_d = O_W'("OK");
                    end
                end
                S_ITEM: begin
                    if (i_hit) begin
                        islot_d = i_idx; inew_d = 1'b0; o_a_d = O_W'("Qty?"); state_d = S_QTY;
                    end else if (i_free) begin
                        islot_d = i_free_idx; inew_d = 1'b1; name_d = bus.i_a; o_a_d = O_W'("Qty?"); state_d = S_QTY;
                    end else o_a_d = O_W'("Full");
                end
                S_QTY: begin
                    if (inew_q) begin
                        item_vld_d[islot_q]  = 1'b1;
                        item_name_d[islot_q] = name_q;
                        item_qty_d[islot_q]  = bus.i_a[QTY_W-1:0];
                    end else begin
                        item_qty_d[islot_q] = qsum[QTY_W] ? {QTY_W{1'b1}} : qsum[QTY_W-1:0];
                    end
                    o_a_d = O_W'("OK");
                end
                S_DITEM: begin
                    if (i_hit) begin item_vld_d[i_idx] = 1'b0; o_a_d = O_W'("OK"); end
                    else o_a_d = O_W'("InvalItem");
                end
                S_BUY: begin
                    if (!i_hit) o_a_d = O_W'("InvalItem");
                    else if (item_qty_q[i_idx] == '0) o_a_d = O_W'("NoStock");
                    else begin item_qty_d[i_idx] = item_qty_q[i_idx] - 1'b1; o_a_d = O_W'("OK"); end
                end
                default: o_a_d = O_W'("InvalCmd");
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_CMD;
            rdy_q      <= 1'b0;
            o_a_q      <= O_W'("Cmd?");
            vld_q      <= 1'b0;
            logged_q   <= 1'b0;
            cur_q      <= '0;
            uslot_q    <= '0;
            islot_q    <= '0;
            inew_q     <= 1'b0;
            name_q     <= '0;
            user_vld_q <= MAX_USERS'(1);
            locked_q   <= '0;
            item_vld_q <= '0;
            for (int i = 0; i < MAX_USERS; i++) begin
                user_name_q[i] <= (i == 0) ? I_W'(ADMIN_USERNAME) : '0;
                user_pass_q[i] <= (i == 0) ? I_W'(ADMIN_PASSWORD) : '0;
                fails_q[i]     <= 4'd0;
            end
            for (int i = 0; i < MAX_ITEMS; i++) begin
                item_name_q[i] <= '0;
                item_qty_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            rdy_q       <= bus.i_rdy;
            o_a_q       <= o_a_d;
            vld_q       <= vld_d;
            logged_q    <= logged_d;
            cur_q       <= cur_d;
            uslot_q     <= uslot_d;
            islot_q     <= islot_d;
            inew_q      <= inew_d;
            name_q      <= name_d;
            user_vld_q  <= user_vld_d;
            locked_q    <= locked_d;
            user_name_q <= user_name_d;
            user_pass_q <= user_pass_d;
            fails_q     <= fails_d;
            item_vld_q  <= item_vld_d;
            item_name_q <= item_name_d;
            item_qty_q  <= item_qty_d;
        end
    end
endmodule

// File: tb/tb_shop_ctrl_v.sv
// tb/tb_shop_ctrl_v.sv - directed self-checking bench for shop_ctrl_v
module tb_shop_ctrl_v;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    shop_ctrl_v_if #(.I_A_NUM_BITS(56), .O_A_NUM_BITS(72), .CUR_W(3)) bus ();

    shop_ctrl_v dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    function automatic logic [55:0] s2i(input string s);
        logic [55:0] v;
        v = '0;
        for (int k = 0; k < s.len(); k++) v = {v[47:0], s[k]};
        return v;
    endfunction

    function automatic logic [71:0] s2o(input string s);
        logic [71:0] v;
        v = '0;
        for (int k = 0; k < s.len(); k++) v = {v[63:0], s[k]};
        return v;
    endfunction

    // One token: strobe, check response + pulse one cycle later, then pulse gone.
    task automatic send_v(input logic [55:0] tk, input string exp);
        logic [71:0] e;
        e = s2o(exp);
        @(negedge clk);
        bus.i_a   = tk;
        bus.i_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_a !== e || bus.o_vld !== 1'b1) begin
            errors++;
            $display("FAIL resp[%s]: o_a=%s o_vld=%b, expected %s o_vld=1", exp, bus.o_a, bus.o_vld, exp);
        end
        bus.i_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_vld !== 1'b0) begin
            errors++;
            $display("FAIL vld_pulse[%s]: o_vld=%b, expected 0", exp, bus.o_vld);
        end
    endtask

    task automatic send(input string tk, input string exp);
        send_v(s2i(tk), exp);
    endtask

    task automatic chk_sess(input string nm, input logic li, input logic [2:0] cu);
        checks++;
        if (bus.o_logged_in !== li || (li && bus.o_cur_user !== cu)) begin
            errors++;
            $display("FAIL %s: logged_in=%b cur_user=%0d, expected logged_in=%b cur_user=%0d",
                     nm, bus.o_logged_in, bus.o_cur_user, li, cu);
        end
    endtask

    task automatic test_reset();
        bus.i_rdy = 1'b0;
        bus.i_a   = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (bus.o_a !== s2o("Cmd?") || bus.o_vld !== 1'b0 || bus.o_logged_in !== 1'b0 || bus.o_cur_user !== 3'd0) begin
            errors++;
            $display("FAIL reset: o_a=%s vld=%b li=%b cu=%0d, expected Cmd? 0 0 0",
                     bus.o_a, bus.o_vld, bus.o_logged_in, bus.o_cur_user);
        end
    endtask

    task automatic test_bad_login();
        send("Login", "Username?");
        send("Adm", "Password?");
        send("Wpw", "InvalPass");
        chk_sess("bad_login_session", 1'b0, 3'd0);
    endtask

    task automatic test_add_user();
        send("Login", "Username?");
        send("Adm", "Password?");
        send("123", "OK");
        chk_sess("admin_session", 1'b1, 3'd0);
        send("AddUsr", "Username?");
        send("Bob", "Password?");
        send("pw1", "OK");
        send("Logout", "Cmd?");
        chk_sess("after_logout", 1'b0, 3'd0);
        send("Login", "Username?");
        send("Bob", "Password?");
        send("pw1", "OK");
        chk_sess("bob_session", 1'b1, 3'd1);
        send("Login", "InvalPerm");
        send("Logout", "Cmd?");
    endtask

    task automatic test_lockout();
        for (int n = 0; n < 3; n++) begin
            send("Login", "Username?");
            send("Bob", "Password?");
            send("bad", "InvalPass");
        end
        send("Login", "Username?");
        send("Bob", "Locked");
        send("Login", "Username?");
        send("Adm", "Password?");
        send("123", "OK");
        send("DelUsr", "Username?");
        send("Adm", "InvalPerm");
        send("DelUsr", "Username?");
        send("Bob", "OK");
        send("DelUsr", "Username?");
        send("Bob", "InvalUser");
    endtask

    task automatic test_items();
        send("AddItem", "Item?");
        send("Pen", "Qty?");
        send_v(56'd2, "OK");
        send("AddUsr", "Username?");
        send("Cat", "Password?");
        send("pw2", "OK");
        send("Logout", "Cmd?");
        send("Login", "Username?");
        send("Cat", "Password?");
        send("pw2", "OK");
        chk_sess("cat_session", 1'b1, 3'd1);
        send("Buy", "Item?");
        send("Pen", "OK");
        send("Buy", "Item?");
        send("Pen", "OK");
        send("Buy", "Item?");
        send("Pen", "NoStock");
        send("Buy", "Item?");
        send("Ink", "InvalItem");
        send("AddItem", "InvalPerm");
        send("Logout", "Cmd?");
    endtask

    task automatic test_saturate_full();
        send("Login", "Username?");
        send("Adm", "Password?");
        send("123", "OK");
        for (int n = 0; n < 2; n++) begin
            send("AddItem", "Item?");
            send("Pen", "Qty?");
            send_v(56'd200, "OK");
        end
        checks++;
        if (dut.item_qty_q[0] !== 8'd255) begin
            errors++;
            $display("FAIL qty_saturate: qty=%0d, expected 255", dut.item_qty_q[0]);
        end
        send("AddUsr", "Username?");
        send("Cat", "InvalUser");
        send("AddUsr", "Username?");
        send("U2", "Password?");
        send("p", "OK");
        send("AddUsr", "Username?");
        send("U3", "Password?");
        send("p", "OK");
        send("AddUsr", "Username?");
        send("U4", "Password?");
        send("p", "OK");
        send("AddUsr", "Username?");
        send("U5", "Full");
        send("DelItem", "Item?");
        send("Pen", "OK");
        send("Buy", "Item?");
        send("Pen", "InvalItem");
        send("Logout", "Cmd?");
    endtask

    task automatic test_no_session();
        send("AddItem", "InvalPerm");
        send("Logout", "InvalPerm");
        send("Buy", "InvalPerm");
        send("sdfsdf", "InvalCmd");
        send_v(56'd0, "InvalCmd");
    endtask

    task automatic test_held_rdy();
        int pulses;
        pulses = 0;
        @(negedge clk);
        bus.i_a   = s2i("Login");
        bus.i_rdy = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (bus.o_vld === 1'b1) pulses++;
        end
        bus.i_rdy = 1'b0;
        checks++;
        if (pulses != 1 || bus.o_a !== s2o("Username?")) begin
            errors++;
            $display("FAIL held_rdy: pulses=%0d o_a=%s, expected 1 Username?", pulses, bus.o_a);
        end
        send("Adm", "Password?");
        send("123", "OK");
        send("Logout", "Cmd?");
    endtask

    task automatic test_reset_mid();
        send("Login", "Username?");
        send("Adm", "Password?");
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_a !== s2o("Cmd?") || bus.o_vld !== 1'b0 || bus.o_logged_in !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: o_a=%s vld=%b li=%b, expected Cmd? 0 0", bus.o_a, bus.o_vld, bus.o_logged_in);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send("123", "InvalCmd");
    endtask

    initial begin
        test_reset();
        test_bad_login();
        test_add_user();
        test_lockout();
        test_items();
        test_saturate_full();
        test_no_session();
        test_held_rdy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
